// File: rtl/io_store_buffer_if.sv
// Store-side and drain-side signals of the IO posted-write buffer.
// The master modport is the processor/sink side; the slave modport is the buffer itself.
interface io_store_buffer_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          stall;
  logic [AW-1:0] direction;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output wr_en, wr_addr, wr_data, out_ready,
    input  stall, direction, out_data, out_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, out_ready,
    output stall, direction, out_data, out_valid
  );
endinterface

// File: rtl/io_store_buffer.sv
// Posted-write buffer between the processor store path and the IO address decoder.
// Mapped stores are queued in a small first-word-fall-through FIFO and drained one at
// a time onto the decoder direction bus; unmapped stores are accepted, discarded and
// counted in a saturating drop counter.
module io_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 24,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  io_store_buffer_if.slave           bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic mapped;
  logic pop;
  logic accept;
  logic push;
  logic drop;

  // Address map decode plus the accept/stall handshake; full/empty comes from count only.
  always_comb begin
    mapped = (bus.wr_addr <= AW'(116)) ||
             ((bus.wr_addr >= AW'(120)) && (bus.wr_addr <= AW'(140)));
    pop    = bus.out_valid & bus.out_ready;
    accept = bus.wr_en & ~flush & ((count < CW'(DEPTH)) | pop);
    push   = accept & mapped;
    drop   = accept & ~mapped;
    bus.stall = bus.wr_en & ~flush & ~accept;
  end

  // Head of queue falls through; an empty buffer parks the bus at all ones so no sink decodes.
  always_comb begin
    bus.out_valid = (count != '0);
    bus.direction = bus.out_valid ? addr_mem[rd_ptr] : '1;
    bus.out_data  = bus.out_valid ? data_mem[rd_ptr] : '0;
  end

  // Storage write on a mapped accept; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.wr_addr;
      data_mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Saturating count of discarded unmapped stores; survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_io_store_buffer.sv
// Testbench for io_store_buffer: directed and randomized stores checked against a
// queue-based reference model of the buffer's accept/drop/drain rules.
module tb_io_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 24;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  io_store_buffer_if #(.AW(AW), .DW(DW)) bus ();

  io_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .flush    (flush),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  entry_t q[$];
  int     drops = 0;

  task automatic compare(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit isMapped(input logic [AW-1:0] a);
    return (a <= 116) || ((a >= 120) && (a <= 140));
  endfunction

  task automatic checkOutput(input string tag);
    entry_t head;
    compare({tag, ".count"}, 32'(count), 32'(q.size()));
    compare({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      head = q[0];
      compare({tag, ".direction"}, 32'(bus.direction), 32'(head.a));
      compare({tag, ".out_data"}, bus.out_data, head.d);
    end else begin
      compare({tag, ".direction"}, 32'(bus.direction), 32'h00FF_FFFF);
      compare({tag, ".out_data"}, bus.out_data, 32'h0);
    end
    compare({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(drops));
  endtask

  // Drive one cycle of inputs (just after a rising edge), check stall, clock, update model, check outputs.
  task automatic applyStimulus(input string tag, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input bit rdy, input bit fl);
    bit     pop_m, acc_m;
    entry_t e;
    bus.wr_en     = we;
    bus.wr_addr   = addr;
    bus.wr_data   = data;
    bus.out_ready = rdy;
    flush         = fl;
    pop_m = (q.size() != 0) && rdy;
    acc_m = we && !fl && ((q.size() < DEPTH) || pop_m);
    #1;
    compare({tag, ".stall"}, 32'(bus.stall), 32'(we && !fl && !acc_m));
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (pop_m) void'(q.pop_front());
      if (acc_m && isMapped(addr)) begin
        e.a = addr;
        e.d = data;
        q.push_back(e);
      end
      if (acc_m && !isMapped(addr) && drops < 255) drops++;
    end
    bus.wr_en     = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int            guard;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b0;
    $display("[TB] start");

    // Reset state
    #12;
    checkOutput("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill with out_ready low
    for (int i = 1; i <= 4; i++)
      applyStimulus("fill", 1'b1, AW'(i * 16), DW'(i), 1'b0, 1'b0);

    // Full: stall without pop, then pop-through store
    applyStimulus("full_stall", 1'b1, 24'h50, 32'd5, 1'b0, 1'b0);
    applyStimulus("full_pop", 1'b1, 24'h50, 32'd5, 1'b1, 1'b0);

    // Drain in order
    for (int i = 0; i < 4; i++)
      applyStimulus("drain1", 1'b0, '0, '0, 1'b1, 1'b0);

    // Unmapped drops
    applyStimulus("drop118", 1'b1, 24'd118, 32'hAA, 1'b0, 1'b0);
    applyStimulus("drop200", 1'b1, 24'd200, 32'hBB, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      ra = AW'($urandom_range(32'h00FF_FFFF, 32'd141));
      applyStimulus("drop_sat", 1'b1, ra, $urandom, 1'b0, 1'b0);
    end

    // Boundary addresses
    applyStimulus("b116", 1'b1, 24'd116, 32'h116, 1'b0, 1'b0);
    applyStimulus("b117", 1'b1, 24'd117, 32'h117, 1'b0, 1'b0);
    applyStimulus("b119", 1'b1, 24'd119, 32'h119, 1'b0, 1'b0);
    applyStimulus("b120", 1'b1, 24'd120, 32'h120, 1'b0, 1'b0);
    applyStimulus("b140", 1'b1, 24'd140, 32'h140, 1'b0, 1'b0);
    applyStimulus("b141", 1'b1, 24'd141, 32'h141, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("bdrain", 1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with simultaneous store and pop
    for (int i = 0; i < 3; i++)
      applyStimulus("pre_flush", 1'b1, AW'(i + 1), DW'(i + 100), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 24'd5, 32'h55, 1'b1, 1'b1);

    // Random push/pop through pointer wrap
    applyStimulus("rfill", 1'b1, 24'd7, $urandom, 1'b0, 1'b0);
    applyStimulus("rfill", 1'b1, 24'd8, $urandom, 1'b0, 1'b0);
    applyStimulus("rdrain", 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ra = AW'($urandom_range(140, 0));
      rd = $urandom;
      applyStimulus("rand", 1'b1, ra, rd, 1'($urandom_range(1, 0)), 1'b0);
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      applyStimulus("rfinal", 1'b0, '0, '0, 1'b1, 1'b0);
      guard++;
    end
    compare("drain_bound", 32'(q.size()), 32'd0);

    // Asynchronous reset between edges
    applyStimulus("pre_rst", 1'b1, 24'd30, 32'h30, 1'b0, 1'b0);
    applyStimulus("pre_rst", 1'b1, 24'd31, 32'h31, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    drops = 0;
    checkOutput("async_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
